// File: rtl/leve_pkg.sv
// Shared types for the AXI read target memory: queued AR request, response codes, R FSM states.
package leve_pkg;

  localparam int AR_ID_W  = 4;
  localparam int AR_IDX_W = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AR_ID_W-1:0]  id;
    logic [7:0]          len;
    logic [AR_IDX_W-1:0] idx;
    logic                err;
  } ar_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rd_state_t;

endpackage

// File: rtl/leve_fifo.sv
// Small synchronous FIFO of an arbitrary packed type; exposes next-cycle fullness for a registered ready.
module leve_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty,
  output logic full_nxt
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wp;
  logic [PW-1:0]  rp;
  logic [PW:0]    cnt;
  logic [PW:0]    cnt_nxt;

  assign cnt_nxt  = cnt + (PW+1)'(push) - (PW+1)'(pop);
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign full_nxt = (cnt_nxt == (PW+1)'(DEPTH));
  assign dout     = mem[rp];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/axi_rd_mem.sv
// AXI read-only target memory: queues AR requests and returns INCR bursts after a fixed latency.
// Build option AXI_RD_MEM_ERR_EN: out-of-range start addresses return DECERR beats with zero data.
module axi_rd_mem
  import leve_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 128,
  parameter int                ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(32'h8000_0000),
  parameter int                DEPTH     = 1024,
  parameter int                AR_DEPTH  = 4,
  parameter int                RD_LAT    = 2,
  parameter string             INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [ID_W-1:0]   ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [ID_W-1:0]   RID,
  output logic              RLAST,
  output logic [1:0]        RRESP
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word offset from BASE with a borrow bit; the byte-within-word bits play no part.
  logic [ADDR_W-4:0] woff;
  logic              addr_err;
  logic              unused_bits;

  assign woff = {1'b0, ARADDR[ADDR_W-1:4]} - {1'b0, BASE[ADDR_W-1:4]};

`ifdef AXI_RD_MEM_ERR_EN
  assign addr_err    = woff[ADDR_W-4] || (woff[ADDR_W-5:0] >= (ADDR_W-4)'(DEPTH));
  assign unused_bits = ^ARADDR[3:0];
`else
  assign addr_err    = 1'b0;
  assign unused_bits = ^{ARADDR[3:0], woff[ADDR_W-4:IDX_W]};
`endif

  ar_req_t push_req;
  ar_req_t head;
  logic    q_full;
  logic    q_empty;
  logic    q_full_nxt;
  logic    push;
  logic    pop;

  // NOTE: every field gets a value on every pass so no latch can be inferred.
  always_comb begin
    push_req     = '0;
    push_req.id  = AR_ID_W'(ARID);
    push_req.len = ARLEN;
    push_req.idx = AR_IDX_W'(woff[IDX_W-1:0]);
    push_req.err = addr_err;
  end

  leve_fifo #(
    .T     (ar_req_t),
    .DEPTH (AR_DEPTH)
  ) u_ar_q (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .push     (push),
    .din      (push_req),
    .pop      (pop),
    .dout     (head),
    .full     (q_full),
    .empty    (q_empty),
    .full_nxt (q_full_nxt)
  );

  rd_state_t         state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic              err_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic              r_hs;

  assign r_hs    = rvalid_q && RREADY;
  assign push    = ARVALID && arready_q;
  assign idx_nxt = idx_q + IDX_W'(1);
  // The queue head is taken when idle, or straight after the final beat so bursts run back to back.
  assign pop     = !q_empty && ((state == IDLE) || ((state == BURST) && r_hs && rlast_q));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= !q_full_nxt;
      case (state)
        IDLE: ;
        WAIT: begin
          if (lat_cnt == '0) begin
            state    <= BURST;
            rvalid_q <= 1'b1;
            rdata_q  <= err_q ? '0 : mem[idx_q];
            rlast_q  <= (len_q == 8'd0);
            beat_q   <= 8'd0;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              state    <= IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              idx_q   <= idx_nxt;
              beat_q  <= beat_q + 8'd1;
              rdata_q <= err_q ? '0 : mem[idx_nxt];
              rlast_q <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A pop overrides the case above: it loads the next transaction and starts its latency count.
      if (pop) begin
        state   <= WAIT;
        lat_cnt <= LAT_W'(RD_LAT - 1);
        len_q   <= head.len;
        idx_q   <= IDX_W'(head.idx);
        err_q   <= head.err;
        rid_q   <= ID_W'(head.id);
        rresp_q <= head.err ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RID     = rid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_rd_mem.sv
// Directed bench for axi_rd_mem: a scoreboard of expected R beats, stall-hold checks and timing checks.
module tb_axi_rd_mem;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 128;
  localparam int          ID_W     = 4;
  localparam int          DEPTH    = 1024;
  localparam int          AR_DEPTH = 4;
  localparam int          RD_LAT   = 2;
  localparam logic [31:0] BASE     = 32'h8000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
    logic [1:0]        resp;
  } beat_t;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic [7:0]        ARLEN = '0;
  logic [ID_W-1:0]   ARID = '0;
  logic              RVALID;
  logic              RREADY = 1'b0;
  logic [DATA_W-1:0] RDATA;
  logic [ID_W-1:0]   RID;
  logic              RLAST;
  logic [1:0]        RRESP;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic  rr_pat_en = 1'b0;
  logic  rr_level = 1'b0;

  axi_rd_mem #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ID_W     (ID_W),
    .BASE     (BASE),
    .DEPTH    (DEPTH),
    .AR_DEPTH (AR_DEPTH),
    .RD_LAT   (RD_LAT)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARID    (ARID),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RID     (RID),
    .RLAST   (RLAST),
    .RRESP   (RRESP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: word 0 ends in ..01, every word distinct.
  function automatic logic [DATA_W-1:0] word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0, 32'h5A5A_5A5A, 32'(i) + 32'd1};
  endfunction

  task automatic exp_burst(input int idx, input int len, input logic [ID_W-1:0] id, input logic err);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.data = err ? '0 : word((idx + k) % DEPTH);
      b.id   = id;
      b.last = (k == len);
      b.resp = err ? 2'b11 : 2'b00;
      exp_q.push_back(b);
    end
  endtask

  // Called aligned to posedge+1; returns aligned to posedge+1 after the handshake edge.
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [ID_W-1:0] id,
                         output int waits);
    logic hs;
    ARADDR  = addr;
    ARLEN   = len;
    ARID    = id;
    ARVALID = 1'b1;
    waits   = 0;
    hs      = 1'b0;
    forever begin
      @(negedge CLK);
      hs = ARREADY;
      @(posedge CLK);
      #1;
      if (hs || waits >= 200) break;
      waits++;
    end
    ARVALID = 1'b0;
    if (!hs) check("ar_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // RREADY driver: either a held level or the repeating 1,0,0,1 pattern.
  initial begin
    logic [3:0] pat;
    int pc;
    pat = 4'b1001;
    pc  = 0;
    forever begin
      @(posedge CLK);
      #1;
      RREADY = rr_pat_en ? pat[pc % 4] : rr_level;
      pc++;
    end
  end

  // Scoreboard: sample at negedge, compare every accepted beat and stall stability.
  initial begin
    beat_t got;
    beat_t held;
    beat_t e;
    logic  stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        stall = 1'b0;
        continue;
      end
      got = {RDATA, RID, RLAST, RRESP};
      if (stall) check("hold", {RVALID, got}, {1'b1, held});
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", got.data, e.data);
          check("rid",   got.id,   e.id);
          check("rlast", got.last, e.last);
          check("rresp", got.resp, e.resp);
        end
      end
      stall = RVALID && !RREADY;
      held  = got;
    end
  end

  initial begin
    int w;
    int tot;
    int lat;
    int seen;
    int hi;

    for (int i = 0; i < DEPTH; i++) dut.mem[i] = word(i);

    // Reset held for three cycles, then ARREADY rises one cycle after release.
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("arready_after_rst", ARREADY, 1);
    check("rvalid_after_rst", RVALID, 0);
    @(posedge CLK);
    #1;

    // Single read: first RVALID 1+RD_LAT cycles after the AR handshake.
    rr_level = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    exp_burst(0, 0, 4'd3, 1'b0);
    send_ar(32'h8000_0000, 8'd0, 4'd3, w);
    lat = 0;
    forever begin
      @(posedge CLK);
      #1;
      lat++;
      if (RVALID || lat >= 20) break;
    end
    check("first_latency", lat, 1 + RD_LAT);
    wait_drain("drain_single");

    // Queue fill with R stalled: one request in the FSM plus four queued, then ARREADY low.
    rr_level = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 6; i++) exp_burst(i, 0, ID_W'(i), 1'b0);
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      send_ar(BASE + 32'(16 * i), 8'd0, ID_W'(i), w);
      tot += w;
    end
    check("fill_waits", tot, 0);
    ARADDR  = BASE + 32'd80;
    ARLEN   = 8'd0;
    ARID    = 4'd5;
    ARVALID = 1'b1;
    hi = 0;
    repeat (3) begin
      @(negedge CLK);
      if (ARREADY) hi++;
    end
    check("arready_full", hi, 0);
    @(posedge CLK);
    #1;
    rr_level = 1'b1;
    send_ar(BASE + 32'd80, 8'd0, 4'd5, w);
    wait_drain("drain_fill");

    // Continuous single-beat stream, returned in issue order.
    for (int i = 0; i < 8; i++) exp_burst(10 + i, 0, ID_W'(i + 8), 1'b0);
    for (int i = 0; i < 8; i++) send_ar(BASE + 32'(16 * (10 + i)), 8'd0, ID_W'(i + 8), w);
    wait_drain("drain_stream");

    // Four-beat burst under 1,0,0,1 backpressure; low address bits are ignored.
    rr_pat_en = 1'b1;
    exp_burst(200, 3, 4'hA, 1'b0);
    send_ar(32'h8000_0C84, 8'd3, 4'hA, w);
    wait_drain("drain_backpressure");
    rr_pat_en = 1'b0;
    rr_level  = 1'b1;

    // Wrap from the last word to word 0.
    exp_burst(1023, 1, 4'h5, 1'b0);
    send_ar(32'h8000_3FF0, 8'd1, 4'h5, w);
    wait_drain("drain_wrap");

    // Below BASE and one past the top.
`ifdef AXI_RD_MEM_ERR_EN
    exp_burst(0, 1, 4'h6, 1'b1);
    exp_burst(0, 0, 4'h7, 1'b1);
`else
    exp_burst(1023, 1, 4'h6, 1'b0);
    exp_burst(0, 0, 4'h7, 1'b0);
`endif
    send_ar(32'h7FFF_FFF0, 8'd1, 4'h6, w);
    send_ar(32'h8000_4000, 8'd0, 4'h7, w);
    wait_drain("drain_range");

    // Reset mid-burst: everything dropped, nothing emitted afterwards.
    rr_level = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    send_ar(BASE, 8'd7, 4'h9, w);
    lat = 0;
    while (!RVALID && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("rvalid_before_rst", RVALID, 1);
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("rst_mid_rvalid", RVALID, 0);
    check("rst_mid_arready", ARREADY, 0);
    check("rst_mid_rlast", RLAST, 0);
    rr_level = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (RVALID) seen++;
    end
    check("no_beat_after_rst", seen, 0);
    @(posedge CLK);
    #1;

    // Normal service resumes after reset.
    exp_burst(7, 0, 4'h2, 1'b0);
    send_ar(32'h8000_0070, 8'd0, 4'h2, w);
    wait_drain("drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
